// File: rtl/dma_pkg.sv
// Shared types for the RAM-to-stream DMA: FSM states and the output FIFO entry.
// Optional checksum output is enabled by defining RAM2STREAM_CHECKSUM_EN.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } dma_state_t;

    localparam int FIFO_DEPTH       = 2;
    localparam int FIFO_CNT_WIDTH   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_DATA_WIDTH = 8;

    typedef struct packed {
        logic [ENTRY_DATA_WIDTH-1:0] data;
        logic                        last;
    } fifo_entry_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with a registered head; the caller guarantees no push when full
// and no pop when empty.
import dma_pkg::*;

module stream_fifo2 (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  fifo_entry_t               din,
    output fifo_entry_t               head,
    output logic [FIFO_CNT_WIDTH-1:0] count
);

    fifo_entry_t               slot_reg [FIFO_DEPTH];
    logic [FIFO_CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_reg + FIFO_CNT_WIDTH'(push) - FIFO_CNT_WIDTH'(pop);
            case ({push, pop})
                2'b10: slot_reg[count_reg[0]] <= din;
                2'b01: slot_reg[0] <= slot_reg[1];
                2'b11: begin
                    // Simultaneous push/pop: a single resident entry is replaced in place.
                    if (count_reg == FIFO_CNT_WIDTH'(1)) begin
                        slot_reg[0] <= din;
                    end else begin
                        slot_reg[0] <= slot_reg[1];
                        slot_reg[1] <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot_reg[0];
    assign count = count_reg;

endmodule

// File: rtl/ram2stream_dma.sv
// Reads num_elements words from a synchronous-read RAM and streams them out with m_last.
// Define RAM2STREAM_CHECKSUM_EN to add a running modulo-2^DATA_WIDTH checksum output.
import dma_pkg::*;

module ram2stream_dma #(
    parameter int  DATA_WIDTH = ENTRY_DATA_WIDTH,
    parameter int  DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH:0]   num_elements,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef RAM2STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    dma_state_t                state_reg;
    dma_state_t                state_next;
    logic [ADDR_WIDTH-1:0]     rd_addr_reg;
    logic [ADDR_WIDTH-1:0]     rd_addr_next;
    logic [ADDR_WIDTH:0]       issue_left_reg;
    logic                      inflight_reg;
    logic                      inflight_last_reg;
    logic [FIFO_CNT_WIDTH-1:0] fifo_count;
    logic [FIFO_CNT_WIDTH:0]   occupancy;
    fifo_entry_t               push_entry;
    fifo_entry_t               head_entry;
    logic                      start_accept;
    logic                      pop;
    logic                      last_issue;

    assign start_accept = (state_reg == IDLE) && start;
    assign pop          = m_valid && m_ready;

    // Reserve a FIFO slot for every read in flight; a same-cycle pop frees one (m_ready -> mem_rd_en path).
    assign occupancy  = (FIFO_CNT_WIDTH+1)'(fifo_count) + (FIFO_CNT_WIDTH+1)'(inflight_reg)
                      - (FIFO_CNT_WIDTH+1)'(pop);
    assign mem_rd_en  = (state_reg == READ) && (occupancy < (FIFO_CNT_WIDTH+1)'(FIFO_DEPTH));
    assign last_issue = mem_rd_en && (issue_left_reg == (ADDR_WIDTH+1)'(1));

    assign rd_addr_next = (rd_addr_reg == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                                  : rd_addr_reg + ADDR_WIDTH'(1);

    assign mem_rd_addr = rd_addr_reg;
    assign busy        = (state_reg == READ) || (state_reg == DRAIN);
    assign done        = (state_reg == FINISH);
    assign m_valid     = (fifo_count != '0);
    assign m_data      = DATA_WIDTH'(head_entry.data);
    assign m_last      = m_valid && head_entry.last;

    assign push_entry.data = ENTRY_DATA_WIDTH'(mem_rd_data);
    assign push_entry.last = inflight_last_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (num_elements == '0) ? FINISH : READ;
                end
            end
            READ:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (pop && m_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= IDLE;
            rd_addr_reg       <= '0;
            issue_left_reg    <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= mem_rd_en;
            inflight_last_reg <= last_issue;
            if (start_accept) begin
                rd_addr_reg    <= src_addr;
                issue_left_reg <= num_elements;
            end else if (mem_rd_en) begin
                rd_addr_reg    <= rd_addr_next;
                issue_left_reg <= issue_left_reg - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    stream_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_reg),
        .pop   (pop),
        .din   (push_entry),
        .head  (head_entry),
        .count (fifo_count)
    );

`ifdef RAM2STREAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_reg <= '0;
        end else if (start_accept) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg + m_data;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_ram2stream_dma.sv
// Scoreboard bench for ram2stream_dma: a RAM/transfer model fills expectation queues,
// a negedge monitor checks reads, beats, stalls, latency and done timing.
`timescale 1ns/1ps
module tb_ram2stream_dma;

    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk          = 1'b0;
    logic          reset        = 1'b0;
    logic          start        = 1'b0;
    logic [AW-1:0] src_addr     = '0;
    logic [AW:0]   num_elements = '0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data  = '0;
    logic          m_valid;
    logic          m_ready      = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef RAM2STREAM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    ram2stream_dma #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .num_elements (num_elements),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
`ifdef RAM2STREAM_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_addr_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit            mon_en        = 0;
    bit            first_pending = 0;
    bit            hs_seen       = 0;
    bit            stall_prev    = 0;
    bit            done_prev     = 0;
    int            start_cyc     = 0;
    int            done_exp_cyc  = -1;
    int            done_cnt      = 0;
    int            hs_cnt        = 0;
    int            first_hs_cyc  = 0;
    int            last_hs_cyc   = 0;
    logic [DW-1:0] stall_data    = '0;
    logic          stall_last    = 1'b0;
    logic [DW-1:0] model_sum     = '0;

    int ready_mode = 0;
    int pat_i      = 0;
    int pat [4]    = '{1, 0, 0, 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1: begin m_ready = pat[pat_i % 4][0]; pat_i++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        beat_t b;
        int    a;
        if (mon_en) begin
            if (stall_prev) begin
                check("stall_valid_held", m_valid, 1);
                check("stall_data_held", m_data, stall_data);
                check("stall_last_held", m_last, stall_last);
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;

            if (mem_rd_en) begin
                if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
                else begin
                    a = exp_addr_q.pop_front();
                    check("rd_addr", mem_rd_addr, a);
                end
            end

            if (m_valid && exp_q.size() == 0) check("unexpected_valid", 1, 0);
            if (m_valid && first_pending) begin
                check("first_valid_latency", cyc - start_cyc, 2);
                first_pending = 0;
            end

            if (m_valid && m_ready) begin
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("beat_data", m_data, b.data);
                    check("beat_last", m_last, b.last);
                end
                if (!hs_seen) begin
                    first_hs_cyc = cyc;
                    hs_seen      = 1;
                end
                last_hs_cyc = cyc;
                hs_cnt++;
                if (m_last) done_exp_cyc = cyc + 1;
            end

            if (done) begin
                check("done_timing", cyc, done_exp_cyc);
                check("busy_at_done", busy, 0);
`ifdef RAM2STREAM_CHECKSUM_EN
                check("checksum", checksum, model_sum);
`endif
                done_cnt++;
                done_exp_cyc = -1;
                if (done_prev) check("done_one_cycle", 1, 0);
            end
            done_prev = done;
        end
    end

    task automatic issue_transfer(input int src, input int n);
        int a;
        model_sum = '0;
        for (int i = 0; i < n; i++) begin
            a = (src + i) % DEPTH;
            exp_addr_q.push_back(a);
            exp_q.push_back('{data: ram[a], last: (i == n - 1)});
            model_sum = model_sum + ram[a];
        end
        @(negedge clk);
        start        = 1'b1;
        src_addr     = AW'(src);
        num_elements = (AW+1)'(n);
        @(posedge clk);
        #1;
        start_cyc     = cyc;
        hs_seen       = 0;
        first_pending = (n != 0);
        if (n == 0) done_exp_cyc = start_cyc;
        start = 1'b0;
        $display("transfer src=%0d n=%0d ready_mode=%0d start_cyc=%0d", src, n, ready_mode, start_cyc);
    endtask

    task automatic wait_done(input string name, input int budget);
        int base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) @(posedge clk);
        check({name, "_done_seen"}, done_cnt - base, 1);
        check({name, "_no_leftover"}, exp_q.size() + exp_addr_q.size(), 0);
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1;

        ready_mode = 0;
        issue_transfer(2, 4);
        wait_done("basic", 40);
        check("basic_back_to_back", last_hs_cyc - first_hs_cyc, 3);

        ready_mode = 1;
        issue_transfer(2, 4);
        wait_done("toggle", 60);

        ready_mode = 0;
        issue_transfer(254, 4);
        wait_done("wrap", 40);

        base = hs_cnt;
        issue_transfer(7, 0);
        wait_done("zero", 10);
        check("zero_no_beats", hs_cnt - base, 0);

        issue_transfer(2, 4);
        @(negedge clk);
        check("busy_mid", busy, 1);
        start        = 1'b1;
        src_addr     = AW'(100);
        num_elements = (AW+1)'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", 40);

        base = hs_cnt;
        issue_transfer(10, 8);
        for (int k = 0; k < 50 && hs_cnt - base < 2; k++) @(posedge clk);
        check("reach_third_beat", hs_cnt - base, 2);
        mon_en = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_en", mem_rd_en, 0);
        check("mid_rst_rd_addr", mem_rd_addr, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_last", m_last, 0);
        exp_q.delete();
        exp_addr_q.delete();
        first_pending = 0;
        stall_prev    = 0;
        done_prev     = 0;
        done_exp_cyc  = -1;
        base = done_cnt;
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1;
        repeat (10) @(posedge clk);
        check("no_done_after_reset", done_cnt - base, 0);

        issue_transfer(0, DEPTH);
        wait_done("full", 400);
        check("full_back_to_back", last_hs_cyc - first_hs_cyc, DEPTH - 1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            ready_mode = 2;
            n = (t == 5) ? 0 : int'($urandom_range(1, 24));
            issue_transfer(int'($urandom_range(0, DEPTH - 1)), n);
            wait_done("random", 20 + 6 * n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
